// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a write FIFO.
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   wr_valid   - write request for wr_data
//   wr_data    - payload word (DATA_BITS)
//   wr_ready   - FIFO not full
//   dout       - serial line, idle high, registered
//   busy       - transmitter FSM not idle
//   fifo_count - occupied FIFO entries
//   overflow   - sticky flag, set when a write hits a full FIFO
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic                          dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               r_state, w_next;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [CW-1:0]        r_count;
    logic [15:0]          r_clk_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par, r_dout, r_overflow;
    logic                 w_full, w_has, w_wr, w_pop, w_tick, w_last_bit, w_last_stop, w_dout;

    assign w_full      = r_count == CW'(FIFO_DEPTH);
    assign w_has       = r_count != '0;
    assign w_wr        = wr_valid && !w_full;
    assign w_tick      = r_clk_cnt == 16'(CLKS_PER_BIT - 1);
    assign w_last_bit  = r_bit_idx == 3'(DATA_BITS - 1);
    // r_bit_idx doubles as the stop-bit index while in STOP
    assign w_last_stop = w_tick && r_bit_idx == 3'(STOP_BITS - 1);
    assign w_dout      = r_state == START ? 1'b0 :
                         r_state == DATA  ? r_shift[0] :
                         r_state == PAR   ? r_par : 1'b1;

    assign wr_ready   = !w_full;
    assign dout       = r_dout;
    assign busy       = r_state != IDLE;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE:  if (w_has) begin
                       w_pop  = 1'b1;
                       w_next = START;
                   end
            START: if (w_tick) w_next = DATA;
            DATA:  if (w_tick && w_last_bit) w_next = (PARITY != 0) ? PAR : STOP;
            PAR:   if (w_tick) w_next = STOP;
            STOP:  if (w_last_stop) begin
                       // back-to-back: pop straight into the next frame
                       w_pop  = w_has;
                       w_next = w_has ? START : IDLE;
                   end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_dout     <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr  <= r_rptr + 1'b1;
                r_shift <= r_mem[r_rptr];
                r_par   <= (PARITY == 1) ? ~^r_mem[r_rptr] : ^r_mem[r_rptr];
            end else if (r_state == DATA && w_tick) begin
                r_shift <= r_shift >> 1;
            end
            r_count    <= r_count + CW'(w_wr) - CW'(w_pop);
            // full is judged on registered state, so a same-cycle pop cannot rescue the write
            r_overflow <= r_overflow | (wr_valid & w_full);
            r_clk_cnt  <= (r_state == IDLE || w_tick) ? '0 : r_clk_cnt + 1'b1;
            if (w_tick && (r_state == DATA || r_state == STOP))
                r_bit_idx <= (r_state == DATA ? w_last_bit : w_last_stop) ? '0 : r_bit_idx + 1'b1;
            // dout follows the state one cycle later, giving write-to-start latency of two edges
            r_dout <= w_dout;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo over four parameter sets.
module tb_uart_tx_fifo;
    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wv [4];
    logic [7:0] wd [4];
    logic       rdy_v [4], dout_v [4], busy_v [4], ovf_v [4];
    logic [4:0] cnt_v [4];

    frame_t exp_q [4][$];
    int     start_log [$];
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DB = (g == 3) ? 7 : 8;
        uart_tx_fifo #(
            .CLKS_PER_BIT(4),
            .DATA_BITS(DB),
            .PARITY(g == 1 ? 2 : g == 2 ? 1 : 0),
            .STOP_BITS(g == 3 ? 2 : 1),
            .FIFO_DEPTH(16)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .wr_valid(wv[g]),
            .wr_data(wd[g][DB-1:0]),
            .wr_ready(rdy_v[g]),
            .dout(dout_v[g]),
            .busy(busy_v[g]),
            .fifo_count(cnt_v[g]),
            .overflow(ovf_v[g])
        );
    end

    function automatic int db(input int k);
        return k == 3 ? 7 : 8;
    endfunction

    function automatic int pt(input int k);
        return k == 1 ? 2 : k == 2 ? 1 : 0;
    endfunction

    function automatic int sb(input int k);
        return k == 3 ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Watches one instance's line; every frame is checked cycle by cycle against the queued entry.
    task automatic mon(input int k);
        frame_t      e;
        logic [11:0] eb;
        logic [7:0]  got;
        logic        gp, bad, ab;
        int          nb, idx;
        forever begin
            @(negedge clk);
            if (rst && dout_v[k] == 1'b0) begin
                if (k == 0) start_log.push_back(cyc);
                if (exp_q[k].size() == 0) begin
                    chk($sformatf("unexpected_frame%0d", k), 1, 0);
                    e = '0;
                end else begin
                    e = exp_q[k].pop_front();
                end
                eb = '1;
                eb[0] = 1'b0;
                for (int i = 0; i < db(k); i++) eb[1+i] = e.d[i];
                idx = 1 + db(k);
                if (pt(k) != 0) begin
                    eb[idx] = e.p;
                    idx++;
                end
                nb  = idx + sb(k);
                got = '0;
                gp  = 1'b0;
                bad = 1'b0;
                ab  = 1'b0;
                for (int j = 0; j < nb * 4; j++) begin
                    if (j > 0) @(negedge clk);
                    if (!rst) begin
                        ab = 1'b1;
                        break;
                    end
                    if (dout_v[k] !== eb[j/4]) bad = 1'b1;
                    if (j % 4 == 2 && j / 4 >= 1 && j / 4 <= db(k)) got[j/4-1] = dout_v[k];
                    if (j % 4 == 2 && pt(k) != 0 && j / 4 == db(k) + 1) gp = dout_v[k];
                end
                if (!ab) chk($sformatf("frame%0d", k), {bad, gp, got}, {1'b0, e.p, e.d});
            end
        end
    endtask

    task automatic run_frame(input int k, input logic [7:0] d, input logic p, input int exp_busy);
        logic [2:0] lat;
        int         n;
        lat = '0;
        n   = 0;
        @(negedge clk);
        wv[k] = 1'b1;
        wd[k] = d;
        exp_q[k].push_back(frame_t'({d, p}));
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            wv[k] = 1'b0;
            if (i < 3) lat[i] = dout_v[k];
            n += int'(busy_v[k]);
        end
        chk($sformatf("latency%0d", k), lat, 3'b011);
        chk($sformatf("busy_len%0d", k), n, exp_busy);
        chk($sformatf("idle_dout%0d", k), dout_v[k], 1);
        chk($sformatf("drained%0d", k), exp_q[k].size(), 0);
    endtask

    initial begin
        int bad_gaps;
        for (int k = 0; k < 4; k++) begin
            wv[k] = 1'b0;
            wd[k] = '0;
        end
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none
        repeat (3) @(negedge clk);
        chk("rst_dout", dout_v[0], 1);
        chk("rst_busy", busy_v[0], 0);
        chk("rst_count", cnt_v[0], 0);
        chk("rst_ready", rdy_v[0], 1);
        chk("rst_overflow", ovf_v[0], 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single frames: 8N1, 8E1, 8O1, 7N2
        run_frame(0, 8'h55, 1'b0, 40);
        run_frame(1, 8'h03, 1'b0, 44);
        run_frame(2, 8'h03, 1'b1, 44);
        run_frame(3, 8'h7F, 1'b0, 40);

        // 18 consecutive writes: 17 fit (one is popped right away), the last is dropped
        start_log.delete();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 17) begin
                chk("full_ready", rdy_v[0], 0);
                chk("full_count", cnt_v[0], 16);
                chk("pre_overflow", ovf_v[0], 0);
            end
            wv[0] = 1'b1;
            wd[0] = 8'(i);
            if (i < 17) exp_q[0].push_back(frame_t'({8'(i), 1'b0}));
        end
        @(negedge clk);
        wv[0] = 1'b0;
        chk("overflow_set", ovf_v[0], 1);
        chk("drop_ready", rdy_v[0], 0);
        chk("drop_count", cnt_v[0], 16);
        for (int t = 0; t < 17 * 40 + 200 && (exp_q[0].size() != 0 || busy_v[0]); t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("burst_drained", exp_q[0].size(), 0);
        chk("burst_frames", start_log.size(), 17);
        bad_gaps = 0;
        for (int i = 1; i < start_log.size(); i++)
            if (start_log[i] - start_log[i-1] != 40) bad_gaps++;
        chk("burst_gaps", bad_gaps, 0);
        chk("overflow_sticky", ovf_v[0], 1);

        // reset in data bit 3 with entries still queued
        @(negedge clk);
        wv[0] = 1'b1;
        wd[0] = 8'hA1;
        exp_q[0].push_back(frame_t'({8'hA1, 1'b0}));
        @(negedge clk);
        wd[0] = 8'hB2;
        exp_q[0].push_back(frame_t'({8'hB2, 1'b0}));
        @(negedge clk);
        wd[0] = 8'hC3;
        exp_q[0].push_back(frame_t'({8'hC3, 1'b0}));
        @(negedge clk);
        wv[0] = 1'b0;
        for (int t = 0; t < 20 && dout_v[0]; t++) @(negedge clk);
        repeat (17) @(negedge clk);
        chk("queued_before_rst", cnt_v[0], 2);
        #2 rst = 1'b0;
        #1;
        chk("async_dout", dout_v[0], 1);
        chk("async_count", cnt_v[0], 0);
        chk("async_busy", busy_v[0], 0);
        chk("async_ready", rdy_v[0], 1);
        chk("async_overflow", ovf_v[0], 0);
        exp_q[0].delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        start_log.delete();
        repeat (150) @(negedge clk);
        chk("no_frames_after_rst", start_log.size(), 0);
        chk("idle_after_rst", dout_v[0], 1);
        run_frame(0, 8'h3C, 1'b0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
